fetch_dispatch_queue: RTL and testbench

Instruction buffer between the fetch stage and the per-slot decoders (R-type, I-type, ...). It accepts fetch bundles of up to IPC instructions per cycle, compacts them in program order into a circular queue, and hands them out one per cycle on the DEC_data / DEC_dataValid interface with a ready back-pressure signal. It also supports a pipeline flush.

---
 rtl/fetch_dispatch_queue.sv | 116 +++++++++++
 tb/tb_fetch_dispatch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_dispatch_queue.sv
// Circular instruction queue between fetch and decode: compacts valid fetch slots in order, dispatches one per cycle.
// Optional macro FDQ_RTYPE_COUNT_EN adds the rtype_count output (popped R-type instructions).
module fetch_dispatch_queue #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int IPC           = 4,
    parameter int DEPTH         = 16,
    parameter int PTR_WIDTH     = 4,
    parameter int OPCODE_WIDTH  = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IPC*DATA_WIDTH-1:0] FET_bundle,
    input  logic [IPC-1:0]            FET_validMask,
    input  logic [ADDRESS_WIDTH-1:0]  FET_pc,
    input  logic                      FET_bundleValid,
    output logic                      FET_ready,
    output logic [DATA_WIDTH-1:0]     DEC_data,
    output logic [ADDRESS_WIDTH-1:0]  DEC_pc,
    output logic                      DEC_dataValid,
    input  logic                      DEC_ready,
    input  logic                      flush,
    output logic [PTR_WIDTH:0]        count
`ifdef FDQ_RTYPE_COUNT_EN
    ,output logic [15:0]              rtype_count
`endif
);

    localparam int CNT_W = PTR_WIDTH + 1;

    if (DEPTH < 2 * IPC || (1 << PTR_WIDTH) != DEPTH || OPCODE_WIDTH > DATA_WIDTH) begin : g_param_check
        $error("fetch_dispatch_queue: inconsistent parameters");
    end

    logic [DATA_WIDTH-1:0]    mem_data [DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_pc   [DEPTH];

    logic [PTR_WIDTH-1:0] head;
    logic [PTR_WIDTH-1:0] tail;
    logic [CNT_W-1:0]     n;
    logic [CNT_W-1:0]     push_n;
    logic [PTR_WIDTH-1:0] wr_addr [IPC];
    logic                 push;
    logic                 pop;

    assign FET_ready     = count <= CNT_W'(DEPTH - IPC);
    assign DEC_dataValid = count != '0;
    assign push          = FET_bundleValid && FET_ready && !flush;
    assign pop           = DEC_dataValid && DEC_ready && !flush;
    assign push_n        = push ? n : '0;

    // Each valid slot lands at tail + (number of valid slots below it), so gaps are squeezed out.
    always_comb begin
        n = '0;
        for (int unsigned i = 0; i < IPC; i++) begin
            wr_addr[i] = tail + n[PTR_WIDTH-1:0];
            if (FET_validMask[i]) begin
                n = n + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned i = 0; i < IPC; i++) begin
                if (FET_validMask[i]) begin
                    mem_data[wr_addr[i]] <= FET_bundle[i*DATA_WIDTH +: DATA_WIDTH];
                    mem_pc[wr_addr[i]]   <= FET_pc + ADDRESS_WIDTH'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + n[PTR_WIDTH-1:0];
            end
            if (pop) begin
                head <= head + PTR_WIDTH'(1);
            end
            count <= count + push_n - {{PTR_WIDTH{1'b0}}, pop};
        end
    end

    always_comb begin
        DEC_data = '0;
        DEC_pc   = '0;
        if (DEC_dataValid) begin
            DEC_data = mem_data[head];
            DEC_pc   = mem_pc[head];
        end
    end

`ifdef FDQ_RTYPE_COUNT_EN
    localparam logic [OPCODE_WIDTH-1:0] RTYPE_OPCODE = OPCODE_WIDTH'(7'b0110011);

    // Survives flush on purpose; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rtype_count <= '0;
        end else if (pop && DEC_data[OPCODE_WIDTH-1:0] == RTYPE_OPCODE) begin
            rtype_count <= rtype_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_dispatch_queue.sv
// Self-checking bench for fetch_dispatch_queue: directed scenarios then random traffic against a queue model.
module tb_fetch_dispatch_queue;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int IPC   = 4;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IPC*DW-1:0] fet_bundle;
    logic [IPC-1:0]    fet_mask;
    logic [AW-1:0]     fet_pc;
    logic              fet_valid;
    logic              fet_ready;
    logic [DW-1:0]     dec_data;
    logic [AW-1:0]     dec_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic              flush;
    logic [PW:0]       count;
`ifdef FDQ_RTYPE_COUNT_EN
    logic [15:0]       rtype_count;
`endif

    always #5 clk = ~clk;

    fetch_dispatch_queue #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .IPC(IPC),
        .DEPTH(DEPTH),
        .PTR_WIDTH(PW),
        .OPCODE_WIDTH(7)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .FET_bundle(fet_bundle),
        .FET_validMask(fet_mask),
        .FET_pc(fet_pc),
        .FET_bundleValid(fet_valid),
        .FET_ready(fet_ready),
        .DEC_data(dec_data),
        .DEC_pc(dec_pc),
        .DEC_dataValid(dec_valid),
        .DEC_ready(dec_ready),
        .flush(flush),
        .count(count)
`ifdef FDQ_RTYPE_COUNT_EN
        ,.rtype_count(rtype_count)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t      q[$];
    logic [15:0] m_rtype = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DW-1:0] ed;
        logic [AW-1:0] ep;
        ed = (q.size() != 0) ? q[0].data : '0;
        ep = (q.size() != 0) ? q[0].pc : '0;
        chk({tag, " count"}, 64'(count), 64'(q.size()));
        chk({tag, " valid"}, 64'(dec_valid), 64'(q.size() != 0));
        chk({tag, " data"}, 64'(dec_data), 64'(ed));
        chk({tag, " pc"}, 64'(dec_pc), 64'(ep));
        chk({tag, " fet_ready"}, 64'(fet_ready), 64'((DEPTH - q.size()) >= IPC));
`ifdef FDQ_RTYPE_COUNT_EN
        chk({tag, " rtype"}, 64'(rtype_count), 64'(m_rtype));
`endif
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
    task automatic cycle(input logic bv, input logic [IPC-1:0] mask, input logic [AW-1:0] pc,
                         input logic [IPC*DW-1:0] b, input logic dr, input logic fl, input string tag);
        logic m_push;
        logic m_pop;
        m_push     = bv && ((DEPTH - q.size()) >= IPC) && !fl;
        m_pop      = (q.size() != 0) && dr && !fl;
        fet_valid  = bv;
        fet_mask   = mask;
        fet_pc     = pc;
        fet_bundle = b;
        dec_ready  = dr;
        flush      = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (m_pop) begin
                if (q[0].data[6:0] == 7'b0110011) m_rtype = m_rtype + 16'd1;
                void'(q.pop_front());
            end
            if (m_push) begin
                for (int i = 0; i < IPC; i++) begin
                    if (mask[i]) q.push_back('{data: b[i*DW +: DW], pc: pc + AW'(i)});
                end
            end
        end
        @(negedge clk);
        check_state(tag);
    endtask

    function automatic logic [IPC*DW-1:0] rand_bundle();
        logic [IPC*DW-1:0] r;
        logic [DW-1:0]     w;
        for (int i = 0; i < IPC; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[6:0] = 7'b0110011;
            r[i*DW +: DW] = w;
        end
        return r;
    endfunction

    initial begin
        logic [IPC*DW-1:0] b1;
        logic [IPC*DW-1:0] b2;
        rst_n      = 1'b0;
        fet_valid  = 1'b0;
        fet_mask   = '0;
        fet_pc     = '0;
        fet_bundle = '0;
        dec_ready  = 1'b0;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        check_state("reset");
        chk("reset fet_ready", 64'(fet_ready), 64'(1));
        rst_n = 1'b1;

        // Scenario 1: one full bundle dispatched in order
        b1 = {32'h00000063, 32'h40208033, 32'h00000013, 32'h00208033};
        cycle(1'b1, 4'hF, 10'h010, b1, 1'b1, 1'b0, "s1 push");
        chk("s1 valid rises", 64'(dec_valid), 64'(1));
        chk("s1 count after push", 64'(count), 64'(4));
        for (int k = 0; k < 4; k++) begin
            chk("s1 dispatch pc", 64'(dec_pc), 64'(10'h010 + k));
            cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, "s1 pop");
            chk("s1 count", 64'(count), 64'(3 - k));
        end
`ifdef FDQ_RTYPE_COUNT_EN
        chk("s1 rtype", 64'(rtype_count), 64'(2));
`endif
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b1, "flush idle");
`ifdef FDQ_RTYPE_COUNT_EN
        chk("rtype kept by flush", 64'(rtype_count), 64'(2));
`endif

        // Scenario 2: sparse mask with PC wrap
        b2 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        cycle(1'b1, 4'b1010, 10'h3FF, b2, 1'b0, 1'b0, "s2 push");
        chk("s2 count", 64'(count), 64'(2));
        chk("s2 head pc", 64'(dec_pc), 64'(0));
        chk("s2 head data", 64'(dec_data), 64'(32'hBBBB0001));
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, "s2 pop");
        chk("s2 second pc", 64'(dec_pc), 64'(2));
        chk("s2 second data", 64'(dec_data), 64'(32'hDDDD0003));
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, "s2 drain");

        // Scenario 3: fill to full under back-pressure
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 4'hF, AW'(16 * k), rand_bundle(), 1'b0, 1'b0, "s3 fill");
            chk("s3 fill count", 64'(count), 64'(4 * (k + 1)));
            chk("s3 fill ready", 64'(fet_ready), 64'(k < 3));
        end
        cycle(1'b1, 4'hF, 10'h200, rand_bundle(), 1'b0, 1'b0, "s3 held");
        chk("s3 held count", 64'(count), 64'(16));
        cycle(1'b1, 4'hF, 10'h200, rand_bundle(), 1'b1, 1'b0, "s3 pop");
        chk("s3 count 15", 64'(count), 64'(15));
        chk("s3 ready at 15", 64'(fet_ready), 64'(0));
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 4'hF, 10'h200, rand_bundle(), 1'b1, 1'b0, "s3 drain");
            chk("s3 drain count", 64'(count), 64'(14 - k));
            chk("s3 drain ready", 64'(fet_ready), 64'(k == 2));
        end
        cycle(1'b1, 4'hF, 10'h200, rand_bundle(), 1'b1, 1'b0, "s3 push+pop");
        chk("s3 push+pop count", 64'(count), 64'(15));
        for (int k = 0; k < 20; k++) cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, "s3 empty");
        chk("s3 empty count", 64'(count), 64'(0));

        // Scenario 4: push+pop at count 5 straddling entry 15 -> 0
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, "s4 flush");
        for (int k = 0; k < 3; k++) cycle(1'b1, 4'hF, AW'(8 * k), rand_bundle(), 1'b0, 1'b0, "s4 fill");
        cycle(1'b1, 4'b0011, 10'h040, rand_bundle(), 1'b0, 1'b0, "s4 fill2");
        for (int k = 0; k < 9; k++) cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, "s4 pop");
        chk("s4 count 5", 64'(count), 64'(5));
        cycle(1'b1, 4'b0111, 10'h080, rand_bundle(), 1'b1, 1'b0, "s4 wrap push");
        chk("s4 count 7", 64'(count), 64'(7));
        for (int k = 0; k < 7; k++) cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, "s4 order");
        chk("s4 empty", 64'(count), 64'(0));

        // Scenario 5: flush beats push and pop
        cycle(1'b1, 4'hF, 10'h0A0, rand_bundle(), 1'b0, 1'b0, "s5 fill");
        cycle(1'b1, 4'hF, 10'h0B0, rand_bundle(), 1'b0, 1'b0, "s5 fill");
        cycle(1'b1, 4'b0001, 10'h0C0, rand_bundle(), 1'b0, 1'b0, "s5 fill");
        chk("s5 count 9", 64'(count), 64'(9));
        cycle(1'b1, 4'hF, 10'h0D0, rand_bundle(), 1'b1, 1'b1, "s5 flush");
        chk("s5 flush count", 64'(count), 64'(0));
        chk("s5 flush valid", 64'(dec_valid), 64'(0));
        chk("s5 flush data", 64'(dec_data), 64'(0));
        cycle(1'b1, 4'hF, 10'h100, rand_bundle(), 1'b0, 1'b0, "s5 refill");
        chk("s5 refill pc", 64'(dec_pc), 64'(10'h100));

        // Asynchronous reset mid-operation
        fet_valid = 1'b0;
        dec_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        q.delete();
        m_rtype = '0;
        chk("async rst count", 64'(count), 64'(0));
        chk("async rst valid", 64'(dec_valid), 64'(0));
        chk("async rst ready", 64'(fet_ready), 64'(1));
`ifdef FDQ_RTYPE_COUNT_EN
        chk("async rst rtype", 64'(rtype_count), 64'(0));
`endif
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_state("after rst");

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, IPC'($urandom), AW'($urandom), rand_bundle(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
